c7bifu_brctl: RTL and testbench
===============================

Name: c7bifu_brctl

Overview:
- Early-redirect controller in the IFU, downstream of the immediate/branch-offset decoder.
- Accepts a decoded direct branch with its PC and branch offset, then computes the target.
- Issues a valid/ready redirect to the fetch unit.
- Tracks outstanding fetch requests and marks wrong-path fetch responses for discard until the pipe is clean.

Parameters:
- MAX_OUTST, 4, maximum outstanding fetch requests.
- OUTST_W, 3, counter width; must be at least clog2(MAX_OUTST+1).

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- dec_valid  in  1  decoded instruction valid.
- dec_ready  out  1  controller accepts decoded instruction.
- dec_pc  in  32  PC of decoded instruction.
- dec_br_offs  in  32  sign-extended, pre-shifted branch offset.
- dec_is_br  in  1  direct PC-relative branch/jump.
- dec_is_cond  in  1  branch is conditional.
- redir_valid  out  1  redirect request to fetch.
- redir_pc  out  32  redirect target.
- redir_ready  in  1  fetch accepts redirect.
- fe_req_fire  in  1  fetch request accepted on bus this cycle.
- fe_req_allow  out  1  fetch may issue a request this cycle.
- fe_rsp_valid  in  1  fetch response returns this cycle.
- rsp_drop  out  1  current response is wrong-path; discard.
- exu_flush  in  1  backend flush; all in-flight fetches become wrong-path.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; outst=0; drop_cnt=0; redir_pc=0.
  - redir_valid=0, rsp_drop=0, busy=0.
  - fe_req_allow=1, dec_ready=1.
- outst counter:
  - outst_nxt = outst + fe_req_fire - fe_rsp_valid.
  - fe_req_allow = (outst < MAX_OUTST) | fe_rsp_valid.
  - fire while outst==MAX_OUTST with no rsp, or rsp while outst==0: illegal; assertion fires, counter saturates at the bound.
- Taken decision:
  - take = dec_is_br & ~dec_is_cond (see Optional Feature).
  - target = dec_pc + dec_br_offs, modulo 2^32, no overflow flag.
- FSM states: IDLE, REDIR, DRAIN.
- IDLE:
  - dec_ready=1.
  - dec_valid & take: redir_pc<=target, drop_cnt<=outst_nxt, go to REDIR. The fire in this cycle counts as wrong-path; the rsp in this cycle is good.
  - dec_valid & ~take: consumed, stay in IDLE.
- REDIR:
  - redir_valid=1, dec_ready=0; redir_pc held stable until handshake.
  - drop_cnt_nxt = drop_cnt + fe_req_fire - rsp_drop.
  - On redir_valid & redir_ready: go to DRAIN if drop_cnt_nxt!=0, else IDLE. A fire in the handshake cycle is still wrong-path.
- DRAIN:
  - dec_ready=0; fires here are right-path and do not touch drop_cnt.
  - drop_cnt decrements per dropped response; go to IDLE in the cycle drop_cnt_nxt==0.
- rsp_drop = fe_rsp_valid & (state!=IDLE) & (drop_cnt!=0). Combinational, same cycle as the response.
- Latency: redir_valid rises the cycle after dec handshake. Minimum branch-to-IDLE is 2 cycles with nothing in flight.
- exu_flush (any state, highest priority):
  - Overrides dec_valid and redir_ready in the same cycle; redir_valid deasserts next cycle and the redirect is abandoned.
  - drop_cnt<=outst_nxt; go to DRAIN if nonzero, else IDLE.
  - dec_ready=0 while exu_flush=1.
- Async reset mid-operation abandons all state immediately; no residual drop.

Optional Feature:
- Macro C7BIFU_BRCTL_BTFN_EN.
- Defined: static backward-taken/forward-not-taken prediction. take = dec_is_br & (~dec_is_cond | dec_br_offs[31]).
- Undefined: conditional branches are never redirected; only unconditional direct jumps redirect.

Decomposition:
- Shared defines header for the IFU holds:
  - FSM state encodings: BRCTL_IDLE=2'd0, BRCTL_REDIR=2'd1, BRCTL_DRAIN=2'd2.
  - Default MAX_OUTST.
- One sub-module, c7bifu_outst_cnt: outstanding-request counter with inc/dec, bound checks and fe_req_allow generation. It is reused for drop_cnt with parameterised width.

Test Plan:
- Idle unconditional jump: dec_pc=0x1000, offs=0x40, outst=0 -> redir_valid next cycle with redir_pc=0x1040; redir_ready immediately -> IDLE; rsp_drop never asserted.
- Drain: outst=3, jump accepted, one fire in the same cycle -> drop_cnt=4. The next 4 responses have rsp_drop=1 and the 5th has rsp_drop=0; busy falls the cycle of the 4th.
- Backpressure: redir_ready held 0 for 5 cycles -> redir_valid and redir_pc stable, dec_ready=0. Two responses during the wait -> both dropped, drop_cnt decremented.
- Flush race: exu_flush=1 in the same cycle as redir_ready=1 with outst=2 -> redirect abandoned, DRAIN with drop_cnt=2, redir_valid=0 next cycle.
- BTFN: dec_is_cond=1, offs=0xFFFFFFF0, pc=0x2000 -> redir_pc=0x1FF0 with macro defined, no redirect without it. Forward offs=0x10 never redirects.
- Bounds: outst=MAX_OUTST -> fe_req_allow=0 unless fe_rsp_valid=1. Async resetn pulse in DRAIN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/c7bifu_brctl_pkg.sv
// Shared IFU defines for the branch redirect controller: FSM encodings and default fetch depth.
package c7bifu_brctl_pkg;

    localparam int BRCTL_MAX_OUTST = 4;

    typedef enum logic [1:0] {
        BRCTL_IDLE  = 2'd0,
        BRCTL_REDIR = 2'd1,
        BRCTL_DRAIN = 2'd2
    } brctl_state_t;

endpackage

// File: rtl/c7bifu_outst_cnt.sv
// Bounded up/down counter with parallel load; saturates at 0 and MAX on illegal moves.
// Latency: cnt updates one cycle after inc/dec/load; cnt_nxt and allow are combinational.
// Backpressure: allow drops when the counter is full unless a decrement frees a slot this cycle.
module c7bifu_outst_cnt
    import c7bifu_brctl_pkg::*;
#(
    parameter int MAX = BRCTL_MAX_OUTST,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         allow
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = load_val;
        end else if (inc && !dec) begin
            cnt_nxt = (cnt == MAX_V) ? cnt : cnt + 1'b1;
        end else if (dec && !inc) begin
            cnt_nxt = (cnt == '0) ? cnt : cnt - 1'b1;
        end
    end

    assign allow = (cnt < MAX_V) | dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && !load) begin
            assert (!(inc && !dec && cnt == MAX_V))
                else $error("c7bifu_outst_cnt: increment past bound %0d", MAX);
            assert (!(dec && !inc && cnt == '0))
                else $error("c7bifu_outst_cnt: decrement below zero");
        end
    end
`endif

endmodule

// File: rtl/c7bifu_brctl.sv
// Early-redirect controller: computes direct branch targets, redirects fetch and drops wrong-path responses.
// Latency: redir_valid rises the cycle after the decode handshake; rsp_drop is same-cycle combinational.
// Backpressure: dec_ready is low outside IDLE or during exu_flush; redir_pc holds until redir_ready.
// Build option C7BIFU_BRCTL_BTFN_EN enables static backward-taken/forward-not-taken prediction.
module c7bifu_brctl
    import c7bifu_brctl_pkg::*;
#(
    parameter int MAX_OUTST = BRCTL_MAX_OUTST,
    parameter int OUTST_W   = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [31:0] dec_pc,
    input  logic [31:0] dec_br_offs,
    input  logic        dec_is_br,
    input  logic        dec_is_cond,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready,
    input  logic        fe_req_fire,
    output logic        fe_req_allow,
    input  logic        fe_rsp_valid,
    output logic        rsp_drop,
    input  logic        exu_flush,
    output logic        busy
);

    brctl_state_t       state, state_nxt;
    logic [OUTST_W-1:0] outst, outst_nxt;
    logic [OUTST_W-1:0] drop_cnt, drop_cnt_nxt;
    logic               drop_load, drop_inc;
    logic               drop_allow_unused;
    logic               take, take_fire;
    logic [31:0]        target;

`ifdef C7BIFU_BRCTL_BTFN_EN
    assign take = dec_is_br & (~dec_is_cond | dec_br_offs[31]);
`else
    assign take = dec_is_br & ~dec_is_cond;
`endif

    assign target    = dec_pc + dec_br_offs;
    assign take_fire = (state == BRCTL_IDLE) & dec_valid & take & ~exu_flush;

    c7bifu_outst_cnt #(.MAX(MAX_OUTST), .W(OUTST_W)) u_outst (
        .clk      (clk),
        .rst_n    (resetn),
        .inc      (fe_req_fire),
        .dec      (fe_rsp_valid),
        .load     (1'b0),
        .load_val ('0),
        .cnt      (outst),
        .cnt_nxt  (outst_nxt),
        .allow    (fe_req_allow)
    );

    // Wrong-path accounting: snapshot of in-flight fetches, grown by fires issued before the redirect lands.
    c7bifu_outst_cnt #(.MAX(MAX_OUTST), .W(OUTST_W)) u_drop (
        .clk      (clk),
        .rst_n    (resetn),
        .inc      (drop_inc),
        .dec      (rsp_drop),
        .load     (drop_load),
        .load_val (outst_nxt),
        .cnt      (drop_cnt),
        .cnt_nxt  (drop_cnt_nxt),
        .allow    (drop_allow_unused)
    );

    assign rsp_drop    = fe_rsp_valid & (state != BRCTL_IDLE) & (drop_cnt != '0);
    assign redir_valid = (state == BRCTL_REDIR);
    assign busy        = (state != BRCTL_IDLE);
    assign dec_ready   = (state == BRCTL_IDLE) & ~exu_flush;
    assign drop_load   = exu_flush | take_fire;
    assign drop_inc    = fe_req_fire & (state == BRCTL_REDIR);

    always_comb begin
        state_nxt = state;
        if (exu_flush) begin
            state_nxt = (outst_nxt != '0) ? BRCTL_DRAIN : BRCTL_IDLE;
        end else begin
            case (state)
                BRCTL_IDLE: begin
                    if (dec_valid && take) state_nxt = BRCTL_REDIR;
                end
                BRCTL_REDIR: begin
                    if (redir_ready)
                        state_nxt = (drop_cnt_nxt != '0) ? BRCTL_DRAIN : BRCTL_IDLE;
                end
                BRCTL_DRAIN: begin
                    if (drop_cnt_nxt == '0) state_nxt = BRCTL_IDLE;
                end
                default: state_nxt = BRCTL_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= BRCTL_IDLE;
            redir_pc <= '0;
        end else begin
            state <= state_nxt;
            if (take_fire) redir_pc <= target;
        end
    end

endmodule

// File: tb/tb_c7bifu_brctl.sv
// Scoreboard bench for c7bifu_brctl: expected redirects and drop flags are queued by stimulus, checked by a monitor.
module tb_c7bifu_brctl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_pc, dec_br_offs;
    logic        dec_is_br, dec_is_cond;
    logic        redir_valid, redir_ready;
    logic [31:0] redir_pc;
    logic        fe_req_fire, fe_req_allow;
    logic        fe_rsp_valid, rsp_drop;
    logic        exu_flush, busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_redir_q[$];
    logic        exp_drop_q[$];

    always #5 clk = ~clk;

    c7bifu_brctl dut (
        .clk(clk), .resetn(resetn),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_br_offs(dec_br_offs),
        .dec_is_br(dec_is_br), .dec_is_cond(dec_is_cond),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
        .fe_req_fire(fe_req_fire), .fe_req_allow(fe_req_allow),
        .fe_rsp_valid(fe_rsp_valid), .rsp_drop(rsp_drop),
        .exu_flush(exu_flush), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dec_valid = 0; dec_pc = 0; dec_br_offs = 0; dec_is_br = 0; dec_is_cond = 0;
        redir_ready = 0; fe_req_fire = 0; fe_rsp_valid = 0; exu_flush = 0;
    endtask

    task automatic set_dec(input logic [31:0] pc, input logic [31:0] offs,
                           input logic is_br, input logic is_cond);
        dec_valid = 1; dec_pc = pc; dec_br_offs = offs; dec_is_br = is_br; dec_is_cond = is_cond;
    endtask

    task automatic fire_n(input int n);
        for (int i = 0; i < n; i++) begin
            fe_req_fire = 1; tick(); fe_req_fire = 0;
        end
    endtask

    task automatic rsp(input logic drop);
        exp_drop_q.push_back(drop);
        fe_rsp_valid = 1; tick(); fe_rsp_valid = 0;
    endtask

    // Monitor: consumes one expectation per redirect handshake and per fetch response.
    always @(negedge clk) begin
        if (resetn) begin
            if (redir_valid && redir_ready && !exu_flush) begin
                if (exp_redir_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_redirect: got pc 0x%08h expected none at %0t", redir_pc, $time);
                end else begin
                    check("redir_pc", redir_pc, exp_redir_q.pop_front());
                end
            end
            if (fe_rsp_valid) begin
                if (exp_drop_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got drop %0b expected none at %0t", rsp_drop, $time);
                end else begin
                    check("rsp_drop", {31'd0, rsp_drop}, {31'd0, exp_drop_q.pop_front()});
                end
            end
        end
    end

    initial begin
        clear_inputs();
        resetn = 1;
        #2 resetn = 0;
        #1;
        check("rst_redir_valid", {31'd0, redir_valid}, 0);
        check("rst_rsp_drop", {31'd0, rsp_drop}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_allow", {31'd0, fe_req_allow}, 1);
        check("rst_dec_ready", {31'd0, dec_ready}, 1);
        check("rst_redir_pc", redir_pc, 0);
        tick(); tick();
        resetn = 1;
        tick();

        // Idle unconditional jump, immediate accept
        set_dec(32'h1000, 32'h40, 1, 0);
        exp_redir_q.push_back(32'h1040);
        tick(); clear_inputs();
        check("t1_redir_valid", {31'd0, redir_valid}, 1);
        check("t1_dec_ready", {31'd0, dec_ready}, 0);
        redir_ready = 1; tick(); redir_ready = 0;
        check("t1_busy_after", {31'd0, busy}, 0);

        // Forward conditional and non-branch never redirect
        set_dec(32'h3000, 32'h10, 1, 1); tick(); clear_inputs();
        check("fwd_cond_busy", {31'd0, busy}, 0);
        set_dec(32'h3000, 32'h10, 0, 0); tick(); clear_inputs();
        check("nonbr_busy", {31'd0, busy}, 0);

        // Backward conditional: redirect only with static prediction
        set_dec(32'h2000, 32'hFFFF_FFF0, 1, 1);
`ifdef C7BIFU_BRCTL_BTFN_EN
        exp_redir_q.push_back(32'h1FF0);
        tick(); clear_inputs();
        check("btfn_busy", {31'd0, busy}, 1);
        redir_ready = 1; tick(); redir_ready = 0;
`else
        tick(); clear_inputs();
        check("btfn_busy", {31'd0, busy}, 0);
`endif

        // Drain: three in flight, plus a fire alongside the jump
        fire_n(3);
        set_dec(32'h4000, 32'h100, 1, 0); fe_req_fire = 1;
        exp_redir_q.push_back(32'h4100);
        tick(); clear_inputs();
        check("full_allow", {31'd0, fe_req_allow}, 0);
        fe_rsp_valid = 1; #1;
        check("full_allow_rsp", {31'd0, fe_req_allow}, 1);
        exp_drop_q.push_back(1'b1);
        tick(); fe_rsp_valid = 0;
        redir_ready = 1; tick(); redir_ready = 0;
        check("drain_busy", {31'd0, busy}, 1);
        rsp(1'b1); rsp(1'b1);
        check("drain_busy_mid", {31'd0, busy}, 1);
        rsp(1'b1);
        check("drain_busy_done", {31'd0, busy}, 0);
        fire_n(1);
        rsp(1'b0);

        // Backpressure with wraparound target
        fire_n(2);
        set_dec(32'h5000, 32'hFFFF_F000, 1, 0);
        exp_redir_q.push_back(32'h4000);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_dec(32'h9000, 32'h20, 1, 0);
            fe_rsp_valid = (i == 1 || i == 3);
            if (fe_rsp_valid) exp_drop_q.push_back(1'b1);
            #1;
            check("bp_redir_valid", {31'd0, redir_valid}, 1);
            check("bp_redir_pc", redir_pc, 32'h4000);
            check("bp_dec_ready", {31'd0, dec_ready}, 0);
            tick(); clear_inputs();
        end
        redir_ready = 1; tick(); redir_ready = 0;
        check("bp_busy_after", {31'd0, busy}, 0);

        // Flush races the redirect handshake
        fire_n(2);
        set_dec(32'h6000, 32'h8, 1, 0); tick(); clear_inputs();
        redir_ready = 1; exu_flush = 1; #1;
        check("flush_dec_ready", {31'd0, dec_ready}, 0);
        tick(); clear_inputs();
        check("flush_redir_valid", {31'd0, redir_valid}, 0);
        check("flush_busy", {31'd0, busy}, 1);
        rsp(1'b1);
        check("flush_busy_mid", {31'd0, busy}, 1);
        rsp(1'b1);
        check("flush_busy_done", {31'd0, busy}, 0);

        // Async reset pulse while draining
        fire_n(1);
        set_dec(32'h7000, 32'h4, 1, 0);
        exp_redir_q.push_back(32'h7004);
        tick(); clear_inputs();
        redir_ready = 1; tick(); redir_ready = 0;
        check("rst_pulse_pre_busy", {31'd0, busy}, 1);
        #2 resetn = 0;
        #1;
        check("rst_pulse_busy", {31'd0, busy}, 0);
        check("rst_pulse_redir_valid", {31'd0, redir_valid}, 0);
        check("rst_pulse_redir_pc", redir_pc, 0);
        check("rst_pulse_dec_ready", {31'd0, dec_ready}, 1);
        check("rst_pulse_allow", {31'd0, fe_req_allow}, 1);
        tick();
        resetn = 1;
        tick();
        fire_n(1);
        rsp(1'b0);

        tick(); tick();
        check("redir_q_empty", exp_redir_q.size(), 0);
        check("drop_q_empty", exp_drop_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
